lcd_char_driver: RTL and testbench
==================================

Name: lcd_char_driver

Overview:
- Responder end of the character-write/update interface that `lcd_control` drives.
- Holds a 2x16 character shadow buffer, filled by `lcd_we` writes addressed by row and column.
- On `update`, streams the whole buffer to an HD44780-compatible panel over a 4-bit bus (E/RS/RW/DB[3:0]).
- Runs the panel power-on initialisation after reset and reports `lcd_busy` while init or refresh is in progress.

Parameters:
- T_PWR_CYC, 750000, power-on wait in clock cycles (15 ms at 50 MHz)
- T_INIT1_CYC, 205000, wait after first 0x3 nibble (4.1 ms)
- T_INIT2_CYC, 5000, wait after second 0x3 nibble (100 us)
- T_E_CYC, 12, E high width in cycles; setup and hold each 2 cycles
- T_NIB_CYC, 50, gap between the two nibbles of a byte (1 us)
- T_CMD_CYC, 2000, wait after each byte (40 us)
- T_CLR_CYC, 82000, wait after the clear command (1.64 ms)

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- lcd_row  in  1  row select: 0 = line 1, 1 = line 2
- lcd_col  in  4  column 0..15
- lcd_char  in  8  character code
- lcd_we  in  1  buffer write strobe; one write per cycle
- update  in  1  refresh request, level or pulse
- lcd_busy  out  1  high during init or refresh
- LCD_E  out  1  panel enable
- LCD_RS  out  1  register select: 0 = command, 1 = data
- LCD_RW  out  1  fixed at 0 (write only)
- LCD_DB  out  4  panel data nibble

Behaviour:
- Reset:
  - lcd_busy=1; LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DB=0.
  - All 32 buffer bytes = 0x20.
  - FSM = PWR_WAIT.
- Buffer writes:
  - Index = {lcd_row, lcd_col}; the byte is written on the clock edge where lcd_we=1.
  - Writes are accepted in every state, including init and refresh. No backpressure.
  - A write to a position not yet sent in the current refresh appears on the panel in that refresh; otherwise it appears in the next one.
- Byte transfer, all outputs registered:
  - Drive RS and the high nibble, 2 cycles setup.
  - E=1 for T_E_CYC cycles, E=0, 2 cycles hold.
  - Wait T_NIB_CYC; send the low nibble the same way.
  - Wait T_CMD_CYC, or T_CLR_CYC when the byte is 0x01.
- Init FSM:
  - PWR_WAIT (T_PWR_CYC)
  - nibble 0x3, wait T_INIT1_CYC
  - nibble 0x3, wait T_INIT2_CYC
  - nibble 0x3, wait T_CMD_CYC
  - nibble 0x2, wait T_CMD_CYC
  - bytes 0x28, 0x06, 0x0C, 0x01
  - IDLE
  - Init nibbles are single nibbles with RS=0.
- IDLE: lcd_busy=0.
  - update=1 sampled in IDLE → lcd_busy=1 on the next cycle, FSM = REFRESH.
  - update during init or refresh is latched as pending; it starts a new refresh immediately after the current one completes, so it is never lost.
  - Multiple pending requests collapse into one.
- REFRESH order:
  - cmd 0x80, data buf[0..15] (RS=1)
  - cmd 0xC0, data buf[16..31]
  - then IDLE
  - A refresh is 34 bytes. lcd_busy falls the cycle after the last T_CMD_CYC wait expires.
- Reset asserted mid-transfer: immediate return to reset values, and the full init sequence restarts.
- Timer: one down-counter, 20 bits wide; reloading it to 0 is legal and means 1 cycle.

Optional Feature:
- Macro LCD_CURSOR_EN.
- Defined:
  - the display-on command is 0x0F (cursor and blink on);
  - after a refresh, one extra command 0x80|0x40*last_row+last_col places the cursor at the most recently written position;
  - lcd_busy covers this extra byte.
- Undefined: display-on is 0x0C; no cursor command is sent.

Decomposition:
- Package lcd_pkg holds:
  - command constants: FUNC_SET 0x28, ENTRY 0x06, DISP_ON 0x0C/0x0F, CLEAR 0x01, LINE1 0x80, LINE2 0xC0;
  - the FSM state enumeration;
  - the nibble/byte timing state encoding.
- Sub-module lcd_nibble_tx does the timing-only work:
  - inputs: start, rs, byte, nibble_only, post_wait;
  - outputs: done, E, RS, DB;
  - it owns the timer.
- The top level owns the buffer, the sequencer and the pending flag.

Test Plan (all timing parameters overridden to 4 except T_E_CYC=2):
- Reset release → lcd_busy=1; init sequence 3,3,3,2,28,06,0C,01 observed on DB/E with RS=0; lcd_busy falls afterwards; RW never 1.
- Write row0 col0 'H' (0x48), row1 col9 '!' (0x21), then pulse update → lcd_busy=1 next cycle; byte stream is 80, 48, 15×20, C0, 9×20, 21, 6×20; RS=1 only on data bytes.
- update held high for one cycle during init → exactly one refresh runs after init; lcd_busy stays high continuously.
- lcd_we to row1 col15 while the refresh is sending row0 → new character appears as byte 34 of the same refresh.
- Reset asserted during the third data byte → outputs return to reset values immediately; buffer reads 0x20; init restarts from PWR_WAIT.
- LCD_CURSOR_EN defined → display-on byte is 0F; after the refresh, cursor byte C9 for the last write at row1 col9.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and timer helper for the HD44780 character driver.
// Build option LCD_CURSOR_EN: display-on with cursor/blink and a trailing cursor-placement command.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET = 8'h28;
    localparam logic [7:0] ENTRY    = 8'h06;
`ifdef LCD_CURSOR_EN
    localparam logic [7:0] DISP_ON  = 8'h0F;
    localparam int         REFRESH_LEN = 35;
`else
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam int         REFRESH_LEN = 34;
`endif
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] LINE1    = 8'h80;
    localparam logic [7:0] LINE2    = 8'hC0;

    localparam int TMR_W    = 20;
    localparam int T_SU_CYC = 2;
    localparam int T_HD_CYC = 2;

    typedef enum logic [1:0] {
        PWR_WAIT,
        INIT_SEQ,
        IDLE,
        REFRESH
    } seq_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP,
        TX_EHIGH,
        TX_HOLD,
        TX_GAP,
        TX_POST
    } tx_state_t;

    // A phase of N cycles loads N-1; a load of 0 lasts exactly one cycle.
    function automatic logic [TMR_W-1:0] tmr_load(input int unsigned cycles);
        return (cycles == 0) ? '0 : TMR_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Panel bus timing engine: sends one nibble or one byte (two nibbles) then waits post_wait.
// Owns the single down-counter; out of reset it times the power-on wait and pulses done.
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int T_PWR_CYC = 750000,
    parameter int T_E_CYC   = 12,
    parameter int T_NIB_CYC = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             rs,
    input  logic [7:0]       data,
    input  logic             nibble_only,
    input  logic [TMR_W-1:0] post_wait,
    output logic             done,
    output logic             e,
    output logic             rs_out,
    output logic [3:0]       db
);

    tx_state_t        state;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] post_reg;
    logic [3:0]       low_nib;
    logic             second;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TX_POST;
            timer    <= tmr_load(T_PWR_CYC);
            post_reg <= '0;
            low_nib  <= '0;
            second   <= 1'b0;
            done     <= 1'b0;
            e        <= 1'b0;
            rs_out   <= 1'b0;
            db       <= '0;
        end else begin
            done <= 1'b0;
            if (state != TX_IDLE && timer != '0) begin
                timer <= timer - 1'b1;
            end else begin
                case (state)
                    TX_IDLE: if (start) begin
                        rs_out   <= rs;
                        db       <= data[7:4];
                        low_nib  <= data[3:0];
                        second   <= nibble_only;
                        post_reg <= post_wait;
                        timer    <= tmr_load(T_SU_CYC);
                        state    <= TX_SETUP;
                    end
                    TX_SETUP: begin
                        e     <= 1'b1;
                        timer <= tmr_load(T_E_CYC);
                        state <= TX_EHIGH;
                    end
                    TX_EHIGH: begin
                        e     <= 1'b0;
                        timer <= tmr_load(T_HD_CYC);
                        state <= TX_HOLD;
                    end
                    TX_HOLD: begin
                        if (second) begin
                            timer <= post_reg;
                            state <= TX_POST;
                        end else begin
                            timer <= tmr_load(T_NIB_CYC);
                            state <= TX_GAP;
                        end
                    end
                    TX_GAP: begin
                        db     <= low_nib;
                        second <= 1'b1;
                        timer  <= tmr_load(T_SU_CYC);
                        state  <= TX_SETUP;
                    end
                    TX_POST: begin
                        done  <= 1'b1;
                        state <= TX_IDLE;
                    end
                    default: state <= TX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/lcd_char_driver.sv
// 2x16 character shadow buffer with HD44780 4-bit init and full-screen refresh sequencer.
// Build option LCD_CURSOR_EN: cursor/blink on, cursor placed at the last written cell after refresh.
module lcd_char_driver
    import lcd_pkg::*;
#(
    parameter int T_PWR_CYC   = 750000,
    parameter int T_INIT1_CYC = 205000,
    parameter int T_INIT2_CYC = 5000,
    parameter int T_E_CYC     = 12,
    parameter int T_NIB_CYC   = 50,
    parameter int T_CMD_CYC   = 2000,
    parameter int T_CLR_CYC   = 82000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       lcd_row,
    input  logic [3:0] lcd_col,
    input  logic [7:0] lcd_char,
    input  logic       lcd_we,
    input  logic       update,
    output logic       lcd_busy,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [3:0] LCD_DB
);

    logic [7:0]       char_buf [32];
    seq_state_t       state;
    logic [5:0]       step;
    logic             inflight, pending;
    logic             tx_start, tx_rs, tx_nib_only, tx_done;
    logic [7:0]       tx_data;
    logic [TMR_W-1:0] tx_post;
    logic [7:0]       cur_byte;
    logic             cur_rs, cur_nib, last_step;
    logic [TMR_W-1:0] cur_post;

    assign LCD_RW = 1'b0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 32; i++) char_buf[i] <= 8'h20;
        end else if (lcd_we) begin
            char_buf[{lcd_row, lcd_col}] <= lcd_char;
        end
    end

`ifdef LCD_CURSOR_EN
    logic [4:0] last_pos;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)        last_pos <= '0;
        else if (lcd_we) last_pos <= {lcd_row, lcd_col};
    end
`endif

    // Byte selection reads the buffer when the transfer is issued, so late writes still land.
    always_comb begin
        cur_byte  = 8'h00;
        cur_rs    = 1'b0;
        cur_nib   = 1'b0;
        last_step = 1'b0;
        if (state == INIT_SEQ) begin
            last_step = (step == 6'd7);
            case (step)
                6'd0, 6'd1, 6'd2: begin cur_byte = 8'h30; cur_nib = 1'b1; end
                6'd3:    begin cur_byte = 8'h20; cur_nib = 1'b1; end
                6'd4:    cur_byte = FUNC_SET;
                6'd5:    cur_byte = ENTRY;
                6'd6:    cur_byte = DISP_ON;
                default: cur_byte = CLEAR;
            endcase
        end else begin
            last_step = (step == 6'(REFRESH_LEN - 1));
            if (step == 6'd0) begin
                cur_byte = LINE1;
            end else if (step == 6'd17) begin
                cur_byte = LINE2;
            end else if (step < 6'd17) begin
                cur_byte = char_buf[5'(step - 6'd1)];
                cur_rs   = 1'b1;
            end else if (step < 6'd34) begin
                cur_byte = char_buf[5'(step - 6'd2)];
                cur_rs   = 1'b1;
            end
`ifdef LCD_CURSOR_EN
            else begin
                cur_byte = {1'b1, last_pos[4], 2'b00, last_pos[3:0]};
            end
`endif
        end
        if (state == INIT_SEQ && step == 6'd0)      cur_post = tmr_load(T_INIT1_CYC);
        else if (state == INIT_SEQ && step == 6'd1) cur_post = tmr_load(T_INIT2_CYC);
        else if (!cur_rs && cur_byte == CLEAR)      cur_post = tmr_load(T_CLR_CYC);
        else                                        cur_post = tmr_load(T_CMD_CYC);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= PWR_WAIT;
            step        <= '0;
            inflight    <= 1'b0;
            pending     <= 1'b0;
            lcd_busy    <= 1'b1;
            tx_start    <= 1'b0;
            tx_rs       <= 1'b0;
            tx_nib_only <= 1'b0;
            tx_data     <= '0;
            tx_post     <= '0;
        end else begin
            tx_start <= 1'b0;
            if (update && state != IDLE) pending <= 1'b1;
            case (state)
                PWR_WAIT: if (tx_done) begin
                    state <= INIT_SEQ;
                    step  <= '0;
                end
                IDLE: if (update || pending) begin
                    state    <= REFRESH;
                    step     <= '0;
                    pending  <= 1'b0;
                    lcd_busy <= 1'b1;
                end
                default: begin
                    if (!inflight) begin
                        tx_start    <= 1'b1;
                        inflight    <= 1'b1;
                        tx_data     <= cur_byte;
                        tx_rs       <= cur_rs;
                        tx_nib_only <= cur_nib;
                        tx_post     <= cur_post;
                    end else if (tx_done) begin
                        inflight <= 1'b0;
                        if (!last_step) begin
                            step <= step + 6'd1;
                        end else if (pending || update) begin
                            // Chain straight into the next refresh so busy never drops.
                            state   <= REFRESH;
                            step    <= '0;
                            pending <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            lcd_busy <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    lcd_nibble_tx #(
        .T_PWR_CYC (T_PWR_CYC),
        .T_E_CYC   (T_E_CYC),
        .T_NIB_CYC (T_NIB_CYC)
    ) u_tx (
        .clk         (CLK),
        .rst_n       (RST),
        .start       (tx_start),
        .rs          (tx_rs),
        .data        (tx_data),
        .nibble_only (tx_nib_only),
        .post_wait   (tx_post),
        .done        (tx_done),
        .e           (LCD_E),
        .rs_out      (LCD_RS),
        .db          (LCD_DB)
    );

endmodule

// File: tb/tb_lcd_char_driver.sv
// Bench for lcd_char_driver: panel nibbles are captured on E falling and checked against a queue.
module tb_lcd_char_driver;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       lcd_row = 1'b0;
    logic [3:0] lcd_col = '0;
    logic [7:0] lcd_char = '0;
    logic       lcd_we = 1'b0;
    logic       update = 1'b0;
    logic       lcd_busy, LCD_E, LCD_RS, LCD_RW;
    logic [3:0] LCD_DB;

    int total = 0;
    int bad   = 0;
    int nib_cnt = 0;
    int rw_bad = 0;

    typedef struct packed {
        logic       rs;
        logic [3:0] nib;
    } nib_t;
    nib_t exp_q[$];

    typedef struct {
        logic       row;
        logic [3:0] col;
        logic [7:0] ch;
        int         pos;
    } wr_vec_t;
    wr_vec_t vecs[3];

    logic [7:0] model[32];
    logic [4:0] model_last;

`ifdef LCD_CURSOR_EN
    localparam logic [7:0] EXP_DISP_ON = 8'h0F;
`else
    localparam logic [7:0] EXP_DISP_ON = 8'h0C;
`endif

    lcd_char_driver #(
        .T_PWR_CYC(4), .T_INIT1_CYC(4), .T_INIT2_CYC(4), .T_E_CYC(2),
        .T_NIB_CYC(4), .T_CMD_CYC(4), .T_CLR_CYC(4)
    ) dut (
        .CLK(CLK), .RST(RST), .lcd_row(lcd_row), .lcd_col(lcd_col),
        .lcd_char(lcd_char), .lcd_we(lcd_we), .update(update),
        .lcd_busy(lcd_busy), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW), .LCD_DB(LCD_DB)
    );

    always #5 CLK = ~CLK;

    // Panel monitor: one nibble per E falling edge while out of reset.
    initial begin
        logic prev_e;
        nib_t got, exp;
        prev_e = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                if (LCD_RW !== 1'b0) rw_bad++;
                if (prev_e && LCD_E === 1'b0) begin
                    nib_cnt++;
                    got = {LCD_RS, LCD_DB};
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_nibble got rs=%0d db=%h, none required", LCD_RS, LCD_DB);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            bad++;
                            $display("FAIL nibble_%0d got rs=%0d db=%h required rs=%0d db=%h",
                                     nib_cnt, got.rs, got.nib, exp.rs, exp.nib);
                        end else begin
                            $display("nibble %0d rs=%0d db=%h ok", nib_cnt, got.rs, got.nib);
                        end
                    end
                end
            end
            prev_e = LCD_E;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end else begin
            $display("check %s = %h ok", name, got);
        end
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b[7:4]});
        exp_q.push_back({rs, b[3:0]});
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 4'h3});
        exp_q.push_back({1'b0, 4'h3});
        exp_q.push_back({1'b0, 4'h3});
        exp_q.push_back({1'b0, 4'h2});
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, EXP_DISP_ON);
        push_byte(1'b0, 8'h01);
    endtask

    task automatic push_cursor();
`ifdef LCD_CURSOR_EN
        push_byte(1'b0, 8'h80 | (model_last[4] ? 8'h40 : 8'h00) | {4'h0, model_last[3:0]});
`endif
    endtask

    task automatic push_refresh();
        push_byte(1'b0, 8'h80);
        for (int i = 0; i < 16; i++) push_byte(1'b1, model[i]);
        push_byte(1'b0, 8'hC0);
        for (int i = 16; i < 32; i++) push_byte(1'b1, model[i]);
        push_cursor();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        model_last = '0;
    endtask

    task automatic do_write(input logic r, input logic [3:0] c, input logic [7:0] ch);
        @(posedge CLK); #1;
        lcd_row = r; lcd_col = c; lcd_char = ch; lcd_we = 1'b1;
        @(posedge CLK); #1;
        lcd_we = 1'b0;
        model[{r, c}] = ch;
        model_last = {r, c};
    endtask

    task automatic pulse_update(input string name);
        @(posedge CLK); #1;
        check({name, "_idle_before"}, 32'(lcd_busy), 32'd0);
        update = 1'b1;
        @(posedge CLK); #1;
        update = 1'b0;
        check({name, "_busy_next"}, 32'(lcd_busy), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (lcd_busy !== 1'b0 && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        check({name, "_idle_reached"}, 32'(lcd_busy), 32'd0);
        check({name, "_stream_done"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_nibbles(input int target, input int budget);
        int n;
        n = 0;
        while (nib_cnt < target && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        check("nibble_progress", 32'(nib_cnt >= target), 32'd1);
    endtask

    initial begin
        int base, n, drops;
        logic [7:0] stream[34];

        vecs[0] = '{row: 1'b0, col: 4'd15, ch: 8'h7E, pos: 16};
        vecs[1] = '{row: 1'b0, col: 4'd0,  ch: 8'h48, pos: 1};
        vecs[2] = '{row: 1'b1, col: 4'd9,  ch: 8'h21, pos: 27};

        // Reset values
        model_reset();
        #1 RST = 1'b0;
        #2;
        check("rst_busy", 32'(lcd_busy), 32'd1);
        check("rst_e",    32'(LCD_E),    32'd0);
        check("rst_rs",   32'(LCD_RS),   32'd0);
        check("rst_rw",   32'(LCD_RW),   32'd0);
        check("rst_db",   32'(LCD_DB),   32'd0);

        // Power-on init
        push_init();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1;
        check("init_busy", 32'(lcd_busy), 32'd1);
        wait_idle("init", 3000);

        // Table-driven writes and the resulting refresh stream
        for (int i = 0; i < 34; i++) stream[i] = 8'h20;
        stream[0]  = 8'h80;
        stream[17] = 8'hC0;
        for (int v = 0; v < 3; v++) begin
            do_write(vecs[v].row, vecs[v].col, vecs[v].ch);
            stream[vecs[v].pos] = vecs[v].ch;
        end
        for (int i = 0; i < 34; i++)
            push_byte((i == 0 || i == 17) ? 1'b0 : 1'b1, stream[i]);
`ifdef LCD_CURSOR_EN
        push_byte(1'b0, 8'hC9);
`endif
        pulse_update("refresh1");
        wait_idle("refresh1", 5000);

        // Late write to row1 col15 while row0 is still going out
        model[31] = 8'h5A;
        model_last = 5'd31;
        push_refresh();
        base = nib_cnt;
        pulse_update("refresh2");
        wait_nibbles(base + 6, 1000);
        do_write(1'b1, 4'd15, 8'h5A);
        wait_idle("refresh2", 5000);

        // Reset during the third data byte, then update requested during init
        push_refresh();
        base = nib_cnt;
        pulse_update("refresh3");
        wait_nibbles(base + 6, 1000);
        n = 0;
        while (LCD_E !== 1'b1 && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        check("third_byte_e_high", 32'(LCD_E), 32'd1);
        #2 RST = 1'b0;
        #1;
        check("midrst_busy", 32'(lcd_busy), 32'd1);
        check("midrst_e",    32'(LCD_E),    32'd0);
        check("midrst_rs",   32'(LCD_RS),   32'd0);
        check("midrst_db",   32'(LCD_DB),   32'd0);
        exp_q.delete();
        model_reset();
        repeat (3) @(posedge CLK);
        push_init();
        push_refresh();
        #1 RST = 1'b1;
        repeat (10) @(posedge CLK);
        #1 update = 1'b1;
        @(posedge CLK); #1;
        update = 1'b0;
        drops = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 8000) begin
            @(posedge CLK); #1;
            if (lcd_busy !== 1'b1) drops++;
            n++;
        end
        check("pending_busy_drops", 32'(drops), 32'd0);
        wait_idle("pending_refresh", 200);
        base = nib_cnt;
        repeat (200) @(posedge CLK);
        #1;
        check("single_refresh_only", 32'(nib_cnt - base), 32'd0);
        check("rw_never_high", 32'(rw_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
